// File: rtl/mccomp_run_ctrl.sv
// Run controller for the multi-cycle CPU: loads a program image with the core held
// in reset, runs it to a halt PC or a cycle limit, then dumps a register range.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LOAD  | accepting program words, writing CPU memory
// HOLD  | core reset held for RST_CYCLES after the load
// RUN   | core running, counting cycles, watching for halt/limit
// DUMP  | core frozen, stepping reg_sel through the dump range
// FIN   | sequence done, one cycle before returning to IDLE
module mccomp_run_ctrl #(
  parameter int          DW         = 32,
  parameter int          AW         = 10,
  parameter int          RST_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES = 32'd100000,
  parameter int          FIRST_REG  = 0,
  parameter int          LAST_REG   = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_rst,
  input  logic [DW-1:0] cpu_pc,
  input  logic [DW-1:0] halt_pc,
  output logic [4:0]    reg_sel,
  input  logic [DW-1:0] reg_data,
  output logic          dump_valid,
  output logic [4:0]    dump_sel,
  output logic [DW-1:0] dump_data,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          ovf,
  output logic [31:0]   run_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DUMP, S_FIN} state_t;

  localparam logic [AW-1:0] ADDR_MAX  = '1;
  localparam logic [4:0]    FIRST_SEL = 5'(FIRST_REG);
  localparam logic [4:0]    LAST_SEL  = 5'(LAST_REG);
  localparam logic [7:0]    HOLD_LOAD = 8'(RST_CYCLES - 1);
  localparam logic [31:0]   LIMIT_TC  = MAX_CYCLES - 32'd1;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_cnt;
  logic [7:0]    hold_cnt;
  logic          ld_acc, halt_hit, limit_hit;

  assign ld_ready  = (state == S_LOAD);
  assign ld_acc    = ld_valid && ld_ready;
  assign halt_hit  = (cpu_pc == halt_pc);
  // limit fires on the RUN cycle that brings run_cycles up to MAX_CYCLES
  assign limit_hit = (run_cycles == LIMIT_TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (ld_acc && ld_last) state_nxt = S_HOLD;
      S_HOLD:  if (hold_cnt == 8'd0) state_nxt = S_RUN;
      S_RUN:   if (halt_hit || limit_hit) state_nxt = S_DUMP;
      S_DUMP:  if (reg_sel == LAST_SEL) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt   <= '0;
      hold_cnt   <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      reg_sel    <= 5'd0;
      dump_valid <= 1'b0;
      dump_sel   <= 5'd0;
      dump_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      ovf        <= 1'b0;
      run_cycles <= 32'd0;
    end else begin
      mem_we     <= 1'b0;
      dump_valid <= 1'b0;
      cpu_rst    <= (state_nxt != S_RUN);
      case (state)
        S_IDLE: begin
          if (start) begin
            done       <= 1'b0;
            timeout    <= 1'b0;
            ovf        <= 1'b0;
            run_cycles <= 32'd0;
            addr_cnt   <= '0;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          // past the top of memory, words are still consumed but never written
          if (ld_acc && !ovf) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_cnt;
            mem_wdata <= ld_data;
            if (addr_cnt == ADDR_MAX) ovf <= 1'b1;
            else                      addr_cnt <= addr_cnt + AW'(1);
          end
          hold_cnt <= HOLD_LOAD;
        end
        S_HOLD: begin
          if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        end
        S_RUN: begin
          if (run_cycles != 32'hFFFF_FFFF) run_cycles <= run_cycles + 32'd1;
          if (!halt_hit && limit_hit) timeout <= 1'b1;
          if (state_nxt == S_DUMP) reg_sel <= FIRST_SEL;
        end
        S_DUMP: begin
          dump_valid <= 1'b1;
          dump_sel   <= reg_sel;
          dump_data  <= reg_data;
          if (reg_sel == LAST_SEL) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            reg_sel <= reg_sel + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
